// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery blocks: FSM state encoding and
// the iteration-counter width helper.
package mont_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FINAL,
        S_DONE
    } mont_state_e;

    // Counter must hold 0..w so the terminal increment does not wrap.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mont_cond_sub.sv
// Final conditional subtraction: y = (a >= n) ? a - n : a, for a < 2n.
module mont_cond_sub #(
    parameter int W = 8
) (
    input  logic [W:0]   a_i,
    input  logic [W-1:0] n_i,
    output logic [W-1:0] y_o
);

    logic [W+1:0] diff;
    logic         ge;

    // The borrow out of one extended subtraction doubles as the compare.
    always_comb begin
        diff = {1'b0, a_i} - {2'b00, n_i};
        ge   = ~diff[W+1];
        y_o  = ge ? W'(diff) : W'(a_i);
    end

endmodule

// File: rtl/mont_redc.sv
// Bit-serial Montgomery reduction: result = dat * 2^-W mod N, one radix-2
// step per cycle, with a valid/ready handshake on both sides.
module mont_redc
    import mont_pkg::*;
#(
    parameter int MOD_WIDTH = 2048
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MOD_WIDTH-1:0] dat,
    input  logic [MOD_WIDTH-1:0] mod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [MOD_WIDTH-1:0] result,
    output logic                 err,
    output logic                 busy
);

    localparam int W     = MOD_WIDTH;
    localparam int CNT_W = cnt_width(W);

    mont_state_e  state_q, state_d;
    logic [W:0]   acc_q, acc_d;
    logic [W-1:0] mod_q, mod_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0] result_q, result_d;
    logic         err_q, err_d;

    logic [W+1:0] sum;
    logic [W-1:0] sub_y;

    // acc stays below 2N, so the W+2-bit sum never overflows before the shift.
    always_comb sum = {1'b0, acc_q} + (acc_q[0] ? {2'b00, mod_q} : '0);

    mont_cond_sub #(.W(W)) u_cond_sub (
        .a_i (acc_q),
        .n_i (mod_q),
        .y_o (sub_y)
    );

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path leaves one unassigned and infers a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        mod_d    = mod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    acc_d = {1'b0, dat};
                    mod_d = mod;
                    cnt_d = '0;
                    err_d = ~mod[0];
                    if (mod[0]) begin
                        state_d = S_ITER;
                    end else begin
                        result_d = '0;
                        state_d  = S_DONE;
                    end
                end
            end
            S_ITER: begin
                acc_d = (W+1)'(sum >> 1);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) state_d = S_FINAL;
            end
            S_FINAL: begin
                result_d = sub_y;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mod_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mod_q    <= mod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mont_redc.sv
// Self-checking bench for mont_redc at W=8 against a modular-inverse model.
module tb_mont_redc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dat = '0;
    logic [W-1:0] mod = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         err;
    logic         busy;

    mont_redc #(.MOD_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dat       (dat),
        .mod       (mod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: d * R^-1 mod n, with R^-1 found by search (n odd).
    function automatic int ref_redc(input int d, input int n);
        int rinv;
        if (n == 1) return 0;
        rinv = -1;
        for (int k = 0; k < n; k++)
            if (((k * 256) % n) == 1) rinv = k;
        return (d * rinv) % n;
    endfunction

    typedef struct {
        int res;
        int err;
        int c_acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    bit   shown = 0;
    int   lat_cur = 0;
    int   last_res = -1;
    int   last_err = -1;
    int   last_lat = -1;
    int   n_acc = 0;
    int   n_out = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after posedge, so negedge sees what the next edge will sample.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            shown = 0;
        end else begin
            check("busy_vs_in_ready", busy, !in_ready);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    if (!shown) begin
                        lat_cur = cyc - q[0].c_acc;
                        check("latency", lat_cur, (q[0].err != 0) ? 1 : W + 2);
                        shown = 1;
                    end
                    check("result", result, q[0].res);
                    check("err", err, q[0].err);
                    if (out_ready) begin
                        last_res = result;
                        last_err = err;
                        last_lat = lat_cur;
                        n_out++;
                        void'(q.pop_front());
                        shown = 0;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.res   = mod[0] ? ref_redc(int'(dat), int'(mod)) : 0;
                e.err   = mod[0] ? 0 : 1;
                e.c_acc = cyc;
                q.push_back(e);
                n_acc++;
            end
        end
    end

    bit rnd_bp  = 0;
    bit rdy_fix = 1;

    task automatic step();
        @(posedge clk);
        #1;
        out_ready = rnd_bp ? ($urandom_range(0, 3) != 0) : rdy_fix;
    endtask

    task automatic send(input int d, input int n);
        bit hs;
        in_valid = 1'b1;
        dat      = W'(d);
        mod      = W'(n);
        for (int i = 0; i < 500; i++) begin
            hs = in_ready;
            step();
            if (hs) begin
                in_valid = 1'b0;
                dat      = W'($urandom);
                mod      = W'($urandom);
                return;
            end
        end
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            if (in_ready && q.size() == 0) return;
            step();
        end
        check("idle_timeout", 0, 1);
    endtask

    initial begin
        int n, d;

        check("model_9_13", ref_redc(9, 13), 1);
        check("model_5_13", ref_redc(5, 13), 2);
        check("model_250_251", ref_redc(250, 251), 50);

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        step();
        step();
        rst_n = 1'b1;
        check("post_rst_in_ready", in_ready, 1);

        send(9, 13);
        wait_idle();
        check("dir_one_res", last_res, 1);
        check("dir_one_err", last_err, 0);
        check("dir_one_lat", last_lat, 10);

        send(5, 13);
        wait_idle();
        check("dir_two_res", last_res, 2);
        send(0, 13);
        wait_idle();
        check("dir_zero_res", last_res, 0);

        send(7, 12);
        wait_idle();
        check("dir_even_res", last_res, 0);
        check("dir_even_err", last_err, 1);
        check("dir_even_lat", last_lat, 1);

        send(200, 13);
        wait_idle();
        check("dir_big_dat_lt_n", int'(last_res < 13), 1);
        check("dir_big_dat_err", last_err, 0);

        // Hold the consumer off while the result sits in DONE.
        rdy_fix   = 0;
        out_ready = 1'b0;
        send(9, 13);
        for (int i = 0; i < 50 && !out_valid; i++) step();
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_result", result, 1);
            check("bp_in_ready", in_ready, 0);
            step();
        end
        rdy_fix   = 1;
        out_ready = 1'b1;
        step();
        check("bp_back_to_idle", in_ready, 1);
        check("bp_last_res", last_res, 1);

        // Abort mid-iteration.
        send(9, 13);
        step();
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_busy", busy, 0);
        step();
        rst_n = 1'b1;
        check("mid_rst_in_ready", in_ready, 1);
        n_acc = n_out;
        send(250, 251);
        wait_idle();
        check("after_rst_res", last_res, 50);

        // Back-to-back random traffic with backpressure.
        rnd_bp = 1;
        for (int i = 0; i < 1000; i++) begin
            n = $urandom_range(0, 127) * 2 + 1;
            d = $urandom_range(0, n - 1);
            send(d, n);
        end
        wait_idle();
        rnd_bp    = 0;
        out_ready = 1'b1;
        check("outputs_vs_accepts", n_out, n_acc);
        check("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mont_redc.md
MONT_REDC -- requirements
Module: mont_redc

Interface
- REQ-001: Parameter MOD_WIDTH, default 2048: operand and modulus width W; Montgomery radix R = 2^W.
- REQ-002: clk  input  1  sole clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: in_valid  input  1  dat/mod valid this cycle.
- REQ-005: in_ready  output  1  block can accept an operand.
- REQ-006: dat  input  W  Montgomery-domain operand aR mod N; dat < N required for exact results.
- REQ-007: mod  input  W  modulus N; must be odd.
- REQ-008: out_valid  output  1  result/err valid.
- REQ-009: out_ready  input  1  consumer accepts result.
- REQ-010: result  output  W  normal-domain value dat*R^-1 mod N.
- REQ-011: err  output  1  even modulus detected for this operation.
- REQ-012: busy  output  1  high in any state except IDLE.

Function
- REQ-013: FSM states: IDLE, ITER, FINAL, DONE.
- REQ-014: in_ready = 1 only in IDLE; handshake = in_valid && in_ready.
- REQ-015: On handshake: dat goes to accumulator acc (W+1 bits), mod to an internal register; iteration counter cleared; err_q = ~mod[0].
- REQ-016: IDLE -> ITER on handshake with mod[0]=1; IDLE -> DONE on handshake with mod[0]=0, result=0, err=1.
- REQ-017: ITER, each cycle: acc <= (acc + (acc[0] ? N : 0)) >> 1; sum computed at W+2 bits, no truncation before the shift.
- REQ-018: ITER runs exactly W cycles (counter 0..W-1, width $clog2(W+1)), then -> FINAL.
- REQ-019: FINAL: result <= (acc >= N) ? acc - N : acc[W-1:0]; -> DONE.
- REQ-020: DONE: out_valid = 1; result and err stable until out_ready sampled high; then -> IDLE.
- REQ-021: Latency: out_valid rises W+2 clock edges after the accepting edge (odd N); 1 edge for even N.
- REQ-022: out_valid && out_ready at DONE with in_valid high: operand not accepted that cycle (in_ready low); it is accepted in the next IDLE cycle.
- REQ-023: dat and mod changes after acceptance have no effect on the operation in flight.
- REQ-024: dat >= N (dat < R): result still < N after FINAL; exactness not guaranteed; no error flagged.
- REQ-025: Throughput: at most one operation per W+3 cycles.

Reset
- REQ-026: rst_n low, any state (including mid-ITER): state=IDLE, out_valid=0, result=0, err=0, busy=0, counter=0, acc=0; in-flight operation discarded, no output produced.
- REQ-027: in_ready = 1 on the first cycle after rst_n deasserts.

Structure
- REQ-028: Package mont_pkg holds the FSM state enum typedef and the counter-width function; shared with modmulti.
- REQ-029: One sub-module, mont_cond_sub: combinational W+1-bit compare-and-subtract used in FINAL; reusable by modmulti.
- REQ-030: No multipliers; datapath limited to one W+2-bit adder, one comparator/subtractor, and registers.

Verification (MOD_WIDTH=8, R=256)
- REQ-031: N=13, dat=9 (Montgomery form of 1) -> result=1, err=0, out_valid 10 edges after acceptance.
- REQ-032: N=13, dat=5 (form of 2) -> result=2; dat=0 -> result=0.
- REQ-033: N=12 (even), dat=7 -> out_valid after 1 edge, result=0, err=1, no ITER cycles.
- REQ-034: N=13, dat=9, out_ready held low 3 cycles in DONE -> out_valid, result=1 stable; in_ready low throughout; IDLE after out_ready.
- REQ-035: rst_n pulsed low at ITER cycle 4 -> all outputs at reset values; next operation N=251, dat=250 -> result=(250*256^-1) mod 251 matches reference model.
- REQ-036: Random odd N, random dat<N, 1000 ops with random out_ready backpressure -> all results equal reference model; no dropped or duplicated outputs.
